depar_cfg_loader: RTL and testbench
===================================

Name: depar_cfg_loader

Overview:
- Parametrised control-path configuration loader for the deparser and its successors.
- Snoops the daisy-chained control AXI-Stream and claims packets whose module ID equals MODULE_ID.
- Unpacks multi-beat payloads into indexed entry writes across RES_COUNT resource tables.
- Forwards every non-matching packet unchanged, one cycle later, to the next module in the chain.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, control bus data width (multiple of 64, ≥256).
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- MODULE_ID, 5, 8-bit module ID this instance claims.
- RES_COUNT, 2, number of resource tables written (1..16).
- ENTRY_WIDTH, 160, bits per table entry (≤ C_S_AXIS_DATA_WIDTH).
- TABLE_DEPTH, 16, entries per table (power of two, 2..256).
- IDX_WIDTH, $clog2(TABLE_DEPTH), table address width.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- c_s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  control data in.
- c_s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  control tuser in.
- c_s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  control tkeep in.
- c_s_axis_tvalid  in  1  beat valid; there is no tready, so every valid beat is consumed.
- c_s_axis_tlast  in  1  last beat of packet.
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  same widths as inputs  registered forwarded stream.
- cfg_wr_en  out  RES_COUNT  one-hot write strobe per resource table.
- cfg_wr_addr  out  IDX_WIDTH  entry index.
- cfg_wr_data  out  ENTRY_WIDTH  entry data.
- cfg_err_ovf  out  1  sticky: index overflow or bad resource ID seen.
- cfg_busy  out  1  high while a claimed packet is in progress.

Behaviour:
- Header beat field positions, with H = C_S_AXIS_DATA_WIDTH-129 (bits above H are reserved):
  - mod_id = tdata[H -: 8]
  - res_id = tdata[H-8 -: 4]
  - start_idx = tdata[H-12 -: 8]
- Reset: all outputs, registers and state are 0; state = IDLE. Asynchronous assertion forces outputs to 0 immediately, including mid-packet; the rest of that packet is ignored until the next tlast.
- FSM states: IDLE, LOAD, FWD, SKIP.
  - IDLE + valid header, mod_id == MODULE_ID → LOAD (or stay IDLE if tlast). Capture res_id; idx_cnt <= start_idx.
  - IDLE + valid header, mod_id != MODULE_ID → FWD (or stay IDLE if tlast). Forward the beat.
  - LOAD: each valid beat writes one entry and idx_cnt increments. Valid & tlast → IDLE.
  - FWD: forward each valid beat. Valid & tlast → IDLE.
  - SKIP: entered after reset-release mid-packet, i.e. the first beat after reset is not treated as a header when a flag is set. Simplification: SKIP is reached only from the error path (see boundary conditions); valid & tlast → IDLE.
- LOAD write: cfg_wr_data = tdata[ENTRY_WIDTH-1:0]; cfg_wr_addr = idx_cnt[IDX_WIDTH-1:0]; cfg_wr_en[res_id] pulses for 1 cycle. Latency: beat at cycle N gives the write at N+1.
- Forwarding latency is exactly 1 cycle; all c_m_axis signals are registered. c_m_axis_tvalid is 0 for claimed packets, so claimed packets are never forwarded.
- tvalid gaps mid-packet: state holds, no writes, c_m_axis_tvalid = 0.
- Boundary conditions:
  - idx_cnt ≥ TABLE_DEPTH: beat dropped, no strobe, cfg_err_ovf <= 1. idx_cnt is 9 bits wide, so it saturates and never wraps.
  - res_id ≥ RES_COUNT: the whole packet is consumed without writes (state SKIP) and cfg_err_ovf <= 1.
  - cfg_err_ovf clears only on reset.
- cfg_busy = (state == LOAD) || (state == SKIP).

Optional Feature:
- Macro: DEPAR_CFG_STATS_EN.
- Defined: adds outputs cfg_pkt_cnt[15:0] and cfg_entry_cnt[15:0].
  - cfg_pkt_cnt increments on tlast of each claimed packet, including header-only ones.
  - cfg_entry_cnt increments on each cfg_wr_en strobe.
  - Both wrap at 16 bits and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package depar_cfg_pkg holds:
  - header offset constant HDR_RSVD_W = 128 and field widths MOD_ID_W = 8, RES_ID_W = 4, IDX_FIELD_W = 8;
  - the state enum {IDLE, LOAD, FWD, SKIP}.
- One sub-module, ctrl_axis_fwd_reg: the 1-cycle registered AXIS forwarding stage with an enable input. It is reused by other pipeline stages on the control chain.

Test Plan:
- Claimed load: header with mod_id=5, res_id=1, start_idx=2, then 3 payload beats with low 160 bits 0xAAA…, 0xBBB…, 0xCCC… (last) → cfg_wr_en=2'b10 at addr 2,3,4 with that data, each 1 cycle after its beat; no c_m_axis_tvalid.
- Forwarding: 4-beat packet with mod_id=3 → identical tdata/tkeep/tuser/tlast on c_m_axis exactly 1 cycle later; no cfg_wr_en.
- Overflow: mod_id=5, res_id=0, start_idx=14, TABLE_DEPTH=16, 4 payload beats → writes at addr 14 and 15 only; cfg_err_ovf=1 and stays 1.
- Bad resource and gaps: mod_id=5, res_id=7 with RES_COUNT=2 → no writes, cfg_err_ovf=1, next packet is processed normally. Separately, tvalid low for 3 cycles mid LOAD packet → indices stay contiguous.
- Reset mid-packet: drop aresetn during the 2nd payload beat → all outputs 0 immediately. After release, a fresh claimed packet writes correctly from its start_idx.
- With DEPAR_CFG_STATS_EN: two claimed packets of 3 and 0 payload beats → cfg_pkt_cnt=2, cfg_entry_cnt=3.

Source files
------------

// File: rtl/depar_cfg_pkg.sv
// Shared constants, header layout and FSM state type for the deparser config loader.
package depar_cfg_pkg;

    localparam int unsigned HDR_RSVD_W   = 128;
    localparam int unsigned MOD_ID_W     = 8;
    localparam int unsigned RES_ID_W     = 4;
    localparam int unsigned IDX_FIELD_W  = 8;
    localparam int unsigned HDR_FIELDS_W = MOD_ID_W + RES_ID_W + IDX_FIELD_W;
    localparam int unsigned CNT_W        = IDX_FIELD_W + 1;
    localparam int unsigned STAT_W       = 16;

    // Header fields sit contiguously just below the reserved top bits.
    typedef struct packed {
        logic [MOD_ID_W-1:0]    mod_id;
        logic [RES_ID_W-1:0]    res_id;
        logic [IDX_FIELD_W-1:0] start_idx;
    } cfg_hdr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FWD  = 2'd2,
        SKIP = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/depar_cfg_loader_fwd.sv
// One-cycle registered AXI-Stream forwarding stage; beats pass only while en is high.
module ctrl_axis_fwd_reg #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned USER_W = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [USER_W-1:0]   s_tuser,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tvalid,
    input  logic                s_tlast,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [USER_W-1:0]   m_tuser,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tvalid,
    output logic                m_tlast
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata  <= '0;
            m_tuser  <= '0;
            m_tkeep  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            m_tvalid <= s_tvalid & en;
            if (s_tvalid && en) begin
                m_tdata <= s_tdata;
                m_tuser <= s_tuser;
                m_tkeep <= s_tkeep;
                m_tlast <= s_tlast;
            end
        end
    end

endmodule

// File: rtl/depar_cfg_loader.sv
// Claims control packets addressed to MODULE_ID and turns their payload into table writes.
// Optional DEPAR_CFG_STATS_EN adds packet and entry counters.
module depar_cfg_loader
    import depar_cfg_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned MODULE_ID            = 5,
    parameter int unsigned RES_COUNT            = 2,
    parameter int unsigned ENTRY_WIDTH          = 160,
    parameter int unsigned TABLE_DEPTH          = 16,
    parameter int unsigned IDX_WIDTH            = $clog2(TABLE_DEPTH)
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    output logic [RES_COUNT-1:0]              cfg_wr_en,
    output logic [IDX_WIDTH-1:0]              cfg_wr_addr,
    output logic [ENTRY_WIDTH-1:0]            cfg_wr_data,
    output logic                              cfg_err_ovf,
`ifdef DEPAR_CFG_STATS_EN
    output logic [STAT_W-1:0]                 cfg_pkt_cnt,
    output logic [STAT_W-1:0]                 cfg_entry_cnt,
`endif
    output logic                              cfg_busy
);

    localparam int unsigned HDR_MSB = C_S_AXIS_DATA_WIDTH - HDR_RSVD_W - 1;

    cfg_state_e             state;
    logic [RES_ID_W-1:0]    res_q;
    logic [CNT_W-1:0]       idx_cnt;

    cfg_hdr_t hdr_c;
    logic     match_c;
    logic     res_bad_c;
    logic     fwd_en_c;

    assign hdr_c     = cfg_hdr_t'(c_s_axis_tdata[HDR_MSB -: HDR_FIELDS_W]);
    assign match_c   = (hdr_c.mod_id == MOD_ID_W'(MODULE_ID));
    assign res_bad_c = (32'(hdr_c.res_id) >= RES_COUNT);
    assign fwd_en_c  = (state == FWD) || ((state == IDLE) && !match_c);

    ctrl_axis_fwd_reg #(
        .DATA_W (C_S_AXIS_DATA_WIDTH),
        .USER_W (C_S_AXIS_TUSER_WIDTH)
    ) u_fwd (
        .clk      (clk),
        .rst_n    (aresetn),
        .en       (fwd_en_c),
        .s_tdata  (c_s_axis_tdata),
        .s_tuser  (c_s_axis_tuser),
        .s_tkeep  (c_s_axis_tkeep),
        .s_tvalid (c_s_axis_tvalid),
        .s_tlast  (c_s_axis_tlast),
        .m_tdata  (c_m_axis_tdata),
        .m_tuser  (c_m_axis_tuser),
        .m_tkeep  (c_m_axis_tkeep),
        .m_tvalid (c_m_axis_tvalid),
        .m_tlast  (c_m_axis_tlast)
    );

    // Packet FSM with registered write strobe; cfg_busy tracks entry to/exit from LOAD/SKIP.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            res_q       <= '0;
            idx_cnt     <= '0;
            cfg_wr_en   <= '0;
            cfg_wr_addr <= '0;
            cfg_wr_data <= '0;
            cfg_err_ovf <= 1'b0;
            cfg_busy    <= 1'b0;
        end else begin
            cfg_wr_en <= '0;
            if (c_s_axis_tvalid) begin
                unique case (state)
                    IDLE: begin
                        if (match_c) begin
                            res_q   <= hdr_c.res_id;
                            idx_cnt <= CNT_W'(hdr_c.start_idx);
                            if (res_bad_c) begin
                                cfg_err_ovf <= 1'b1;
                                if (!c_s_axis_tlast) begin
                                    state    <= SKIP;
                                    cfg_busy <= 1'b1;
                                end
                            end else if (!c_s_axis_tlast) begin
                                state    <= LOAD;
                                cfg_busy <= 1'b1;
                            end
                        end else if (!c_s_axis_tlast) begin
                            state <= FWD;
                        end
                    end
                    LOAD: begin
                        if (idx_cnt >= CNT_W'(TABLE_DEPTH)) begin
                            cfg_err_ovf <= 1'b1;
                        end else begin
                            cfg_wr_en   <= RES_COUNT'(1) << res_q;
                            cfg_wr_addr <= idx_cnt[IDX_WIDTH-1:0];
                            cfg_wr_data <= c_s_axis_tdata[ENTRY_WIDTH-1:0];
                        end
                        // Saturate so a long packet can never wrap back into range.
                        if (idx_cnt != '1) begin
                            idx_cnt <= idx_cnt + CNT_W'(1);
                        end
                        if (c_s_axis_tlast) begin
                            state    <= IDLE;
                            cfg_busy <= 1'b0;
                        end
                    end
                    FWD: begin
                        if (c_s_axis_tlast) begin
                            state <= IDLE;
                        end
                    end
                    SKIP: begin
                        if (c_s_axis_tlast) begin
                            state    <= IDLE;
                            cfg_busy <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DEPAR_CFG_STATS_EN
    logic pkt_done_c;

    assign pkt_done_c = c_s_axis_tvalid && c_s_axis_tlast &&
                        (((state == IDLE) && match_c) || (state == LOAD) || (state == SKIP));

    // Free-running wrap-around statistics.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_pkt_cnt   <= '0;
            cfg_entry_cnt <= '0;
        end else begin
            if (pkt_done_c) begin
                cfg_pkt_cnt <= cfg_pkt_cnt + STAT_W'(1);
            end
            if (|cfg_wr_en) begin
                cfg_entry_cnt <= cfg_entry_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_depar_cfg_loader.sv
// Directed self-checking bench for depar_cfg_loader (default parameters).
module tb_depar_cfg_loader;

    localparam int unsigned DW = 512;
    localparam int unsigned UW = 128;

    logic            clk;
    logic            aresetn;
    logic [DW-1:0]   s_tdata;
    logic [UW-1:0]   s_tuser;
    logic [DW/8-1:0] s_tkeep;
    logic            s_tvalid;
    logic            s_tlast;
    logic [DW-1:0]   m_tdata;
    logic [UW-1:0]   m_tuser;
    logic [DW/8-1:0] m_tkeep;
    logic            m_tvalid;
    logic            m_tlast;
    logic [1:0]      wr_en;
    logic [3:0]      wr_addr;
    logic [159:0]    wr_data;
    logic            err_ovf;
    logic            busy;
`ifdef DEPAR_CFG_STATS_EN
    logic [15:0]     pkt_cnt;
    logic [15:0]     entry_cnt;
`endif

    int checks;
    int failures;

    depar_cfg_loader dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .c_s_axis_tdata  (s_tdata),
        .c_s_axis_tuser  (s_tuser),
        .c_s_axis_tkeep  (s_tkeep),
        .c_s_axis_tvalid (s_tvalid),
        .c_s_axis_tlast  (s_tlast),
        .c_m_axis_tdata  (m_tdata),
        .c_m_axis_tuser  (m_tuser),
        .c_m_axis_tkeep  (m_tkeep),
        .c_m_axis_tvalid (m_tvalid),
        .c_m_axis_tlast  (m_tlast),
        .cfg_wr_en       (wr_en),
        .cfg_wr_addr     (wr_addr),
        .cfg_wr_data     (wr_data),
        .cfg_err_ovf     (err_ovf),
`ifdef DEPAR_CFG_STATS_EN
        .cfg_pkt_cnt     (pkt_cnt),
        .cfg_entry_cnt   (entry_cnt),
`endif
        .cfg_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Header: mod_id [383:376], res_id [375:372], start_idx [371:364]; filler elsewhere.
    function automatic logic [DW-1:0] hdr(input logic [7:0] mod, input logic [3:0] res,
                                          input logic [7:0] idx);
        logic [DW-1:0] h;
        h = {DW/32{32'h1357_9BDF}};
        h[511:384] = '0;
        h[383 -: 8] = mod;
        h[375 -: 4] = res;
        h[371 -: 8] = idx;
        return h;
    endfunction

    function automatic logic [DW-1:0] pay(input logic [3:0] hi, input logic [3:0] lo);
        return {{88{hi}}, {40{lo}}};
    endfunction

    // Present one beat, let it be clocked, and return #1 after the edge.
    task automatic beat(input logic [DW-1:0] d, input logic last);
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = pay(4'h9, 4'h9);
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] fd [4];
    logic [UW-1:0] fu [4];
    logic [DW/8-1:0] fk [4];

    initial begin
        checks   = 0;
        failures = 0;
        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        s_tkeep  = '1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", DW'(m_tvalid), '0);
        chk("rst_wr_en", DW'(wr_en), '0);
        chk("rst_err", DW'(err_ovf), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_m_tdata", m_tdata, '0);
        #2 aresetn = 1'b1;
        @(posedge clk);
        #1;

        // Claimed load: res 1, start 2, three entries.
        beat(hdr(8'd5, 4'd1, 8'd2), 1'b0);
        chk("ld_hdr_en", DW'(wr_en), '0);
        chk("ld_hdr_busy", DW'(busy), DW'(1));
        beat(pay(4'h1, 4'hA), 1'b0);
        chk("ld0_en", DW'(wr_en), DW'(2'b10));
        chk("ld0_addr", DW'(wr_addr), DW'(2));
        chk("ld0_data", DW'(wr_data), DW'({40{4'hA}}));
        chk("ld0_fwd", DW'(m_tvalid), '0);
        beat(pay(4'h2, 4'hB), 1'b0);
        chk("ld1_en", DW'(wr_en), DW'(2'b10));
        chk("ld1_addr", DW'(wr_addr), DW'(3));
        chk("ld1_data", DW'(wr_data), DW'({40{4'hB}}));
        beat(pay(4'h3, 4'hC), 1'b1);
        chk("ld2_en", DW'(wr_en), DW'(2'b10));
        chk("ld2_addr", DW'(wr_addr), DW'(4));
        chk("ld2_data", DW'(wr_data), DW'({40{4'hC}}));
        chk("ld2_fwd", DW'(m_tvalid), '0);
        chk("ld2_busy", DW'(busy), '0);
        gap();
        chk("ld_end_en", DW'(wr_en), '0);

        // Forwarding: mod_id 3, four beats with distinct sideband.
        fd[0] = hdr(8'd3, 4'd1, 8'd0);
        fd[1] = pay(4'h4, 4'h5);
        fd[2] = pay(4'h6, 4'h7);
        fd[3] = hdr(8'd5, 4'd0, 8'd1);
        for (int i = 0; i < 4; i++) begin
            fu[i] = UW'(128'h1111_0000_0000_0000_0000_0000_0000_0000) + UW'(i * 7 + 3);
            fk[i] = {DW/8{1'b1}} >> (i * 5);
        end
        for (int i = 0; i < 4; i++) begin
            s_tuser = fu[i];
            s_tkeep = fk[i];
            beat(fd[i], (i == 3));
            chk("fwd_valid", DW'(m_tvalid), DW'(1));
            chk("fwd_data", m_tdata, fd[i]);
            chk("fwd_user", DW'(m_tuser), DW'(fu[i]));
            chk("fwd_keep", DW'(m_tkeep), DW'(fk[i]));
            chk("fwd_last", DW'(m_tlast), DW'(i == 3));
            chk("fwd_no_wr", DW'(wr_en), '0);
            chk("fwd_busy", DW'(busy), '0);
        end
        s_tkeep = '1;
        s_tuser = '0;
        gap();
        chk("fwd_end_valid", DW'(m_tvalid), '0);

        // Gaps inside a claimed packet keep indices contiguous.
        beat(hdr(8'd5, 4'd1, 8'd8), 1'b0);
        beat(pay(4'h5, 4'hD), 1'b0);
        chk("gap0_addr", DW'(wr_addr), DW'(8));
        chk("gap0_en", DW'(wr_en), DW'(2'b10));
        for (int i = 0; i < 3; i++) begin
            gap();
            chk("gap_no_wr", DW'(wr_en), '0);
            chk("gap_busy", DW'(busy), DW'(1));
            chk("gap_no_fwd", DW'(m_tvalid), '0);
        end
        beat(pay(4'h6, 4'hE), 1'b1);
        chk("gap1_en", DW'(wr_en), DW'(2'b10));
        chk("gap1_addr", DW'(wr_addr), DW'(9));
        chk("gap1_data", DW'(wr_data), DW'({40{4'hE}}));
        chk("gap_err", DW'(err_ovf), '0);

        // Bad resource id: whole packet skipped, error set.
        beat(hdr(8'd5, 4'd7, 8'd0), 1'b0);
        chk("bad_err", DW'(err_ovf), DW'(1));
        chk("bad_busy", DW'(busy), DW'(1));
        beat(pay(4'h7, 4'h1), 1'b0);
        chk("bad_no_wr", DW'(wr_en), '0);
        chk("bad_no_fwd", DW'(m_tvalid), '0);
        beat(pay(4'h7, 4'h2), 1'b1);
        chk("bad_no_wr2", DW'(wr_en), '0);
        chk("bad_busy_end", DW'(busy), '0);
        beat(hdr(8'd5, 4'd0, 8'd5), 1'b0);
        beat(pay(4'h8, 4'h3), 1'b1);
        chk("after_bad_en", DW'(wr_en), DW'(2'b01));
        chk("after_bad_addr", DW'(wr_addr), DW'(5));
        chk("after_bad_err", DW'(err_ovf), DW'(1));

        // Reset asserted during the second payload beat.
        beat(hdr(8'd5, 4'd1, 8'd0), 1'b0);
        beat(pay(4'h1, 4'h4), 1'b0);
        chk("pre_rst_en", DW'(wr_en), DW'(2'b10));
        s_tdata = pay(4'h1, 4'h5);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_en", DW'(wr_en), '0);
        chk("mid_rst_err", DW'(err_ovf), '0);
        chk("mid_rst_busy", DW'(busy), '0);
        chk("mid_rst_data", DW'(wr_data), '0);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk);
        #3 aresetn = 1'b1;
        beat(hdr(8'd5, 4'd1, 8'd3), 1'b0);
        beat(pay(4'h2, 4'h6), 1'b1);
        chk("post_rst_en", DW'(wr_en), DW'(2'b10));
        chk("post_rst_addr", DW'(wr_addr), DW'(3));
        chk("post_rst_data", DW'(wr_data), DW'({40{4'h6}}));

        // Index overflow: start 14, four beats, only 14 and 15 written.
        beat(hdr(8'd5, 4'd0, 8'd14), 1'b0);
        chk("ovf_hdr_err", DW'(err_ovf), '0);
        beat(pay(4'h3, 4'h1), 1'b0);
        chk("ovf0_en", DW'(wr_en), DW'(2'b01));
        chk("ovf0_addr", DW'(wr_addr), DW'(14));
        beat(pay(4'h3, 4'h2), 1'b0);
        chk("ovf1_en", DW'(wr_en), DW'(2'b01));
        chk("ovf1_addr", DW'(wr_addr), DW'(15));
        chk("ovf1_err", DW'(err_ovf), '0);
        beat(pay(4'h3, 4'h3), 1'b0);
        chk("ovf2_en", DW'(wr_en), '0);
        chk("ovf2_err", DW'(err_ovf), DW'(1));
        beat(pay(4'h3, 4'h4), 1'b1);
        chk("ovf3_en", DW'(wr_en), '0);
        gap();
        gap();
        chk("ovf_sticky", DW'(err_ovf), DW'(1));

        // Header-only claimed packet: no write, not busy afterwards.
        beat(hdr(8'd5, 4'd0, 8'd0), 1'b1);
        chk("hdr_only_en", DW'(wr_en), '0);
        chk("hdr_only_busy", DW'(busy), '0);
        chk("hdr_only_fwd", DW'(m_tvalid), '0);
        gap();
`ifdef DEPAR_CFG_STATS_EN
        // Since the last reset: three claimed packets, three strobes.
        chk("stat_pkt", DW'(pkt_cnt), DW'(3));
        chk("stat_entry", DW'(entry_cnt), DW'(3));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
